// File: rtl/cs161_control_fsm_if.sv
// Control bus between the cs161 multicycle controller and its datapath.
// The master side is the controller; the slave side is the datapath.
interface cs161_control_fsm_if #(
    parameter int OPW    = 6,
    parameter int ALUOPW = 4
);
    logic [OPW-1:0]    instr_op;
    logic [OPW-1:0]    funct;
    logic              mem_ready;
    logic              pc_write;
    logic              ir_write;
    logic              reg_dst;
    logic              branch;
    logic              mem_read;
    logic              mem_to_reg;
    logic [ALUOPW-1:0] alu_op;
    logic              mem_write;
    logic              alu_src;
    logic              reg_write;
    logic              illegal_op;
    logic [2:0]        state_dbg;

    modport master (
        input  instr_op, funct, mem_ready,
        output pc_write, ir_write, reg_dst, branch, mem_read, mem_to_reg,
               alu_op, mem_write, alu_src, reg_write, illegal_op, state_dbg
    );

    modport slave (
        output instr_op, funct, mem_ready,
        input  pc_write, ir_write, reg_dst, branch, mem_read, mem_to_reg,
               alu_op, mem_write, alu_src, reg_write, illegal_op, state_dbg
    );
endinterface

// File: rtl/cs161_control_fsm.sv
// Multicycle main control FSM for the cs161 MIPS datapath (FETCH/DECODE/EXEC/MEM/WB).
// Define CS161_CTRL_PERF_EN to add the retired_count instruction counter port.
//
// state  | meaning
// FETCH  | load IR, PC <= PC+4
// DECODE | latch opcode/funct, reject unsupported opcodes
// EXEC   | ALU operation for the latched opcode; beq resolves here
// MEM    | lw/sw request held until mem_ready
// WB     | single-cycle register file write
module cs161_control_fsm #(
    parameter int OPW    = 6,
    parameter int ALUOPW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    cs161_control_fsm_if.master  bus
`ifdef CS161_CTRL_PERF_EN
    ,
    output logic [31:0]          retired_count
`endif
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'h00);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'h23);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'h2B);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'h08);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'h04);
    localparam logic [OPW-1:0] OP_ANDI  = OPW'(6'h0C);
    localparam logic [OPW-1:0] OP_ORI   = OPW'(6'h0D);
    localparam logic [OPW-1:0] OP_SLTI  = OPW'(6'h0A);

    localparam logic [ALUOPW-1:0] ALU_ADD   = ALUOPW'(4'b0000);
    localparam logic [ALUOPW-1:0] ALU_SUB   = ALUOPW'(4'b0001);
    localparam logic [ALUOPW-1:0] ALU_FUNCT = ALUOPW'(4'b0010);
    localparam logic [ALUOPW-1:0] ALU_AND   = ALUOPW'(4'b0011);
    localparam logic [ALUOPW-1:0] ALU_OR    = ALUOPW'(4'b0100);
    localparam logic [ALUOPW-1:0] ALU_SLT   = ALUOPW'(4'b0101);

    state_t            state_q, state_d;
    logic [OPW-1:0]    op_q, op_d;
    logic [OPW-1:0]    funct_q, funct_d;
    logic              illegal_q, illegal_d;

    logic              pc_write;
    logic              ir_write;
    logic              reg_dst;
    logic              branch;
    logic              mem_read;
    logic              mem_to_reg;
    logic [ALUOPW-1:0] alu_op;
    logic              mem_write;
    logic              alu_src;
    logic              reg_write;

    function automatic logic is_supported(input logic [OPW-1:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_ADDI,
            OP_BEQ, OP_ANDI, OP_ORI, OP_SLTI: is_supported = 1'b1;
            default:                          is_supported = 1'b0;
        endcase
    endfunction

    function automatic logic [ALUOPW-1:0] exec_alu_op(input logic [OPW-1:0] op);
        case (op)
            OP_RTYPE: exec_alu_op = ALU_FUNCT;
            OP_BEQ:   exec_alu_op = ALU_SUB;
            OP_ANDI:  exec_alu_op = ALU_AND;
            OP_ORI:   exec_alu_op = ALU_OR;
            OP_SLTI:  exec_alu_op = ALU_SLT;
            default:  exec_alu_op = ALU_ADD;
        endcase
    endfunction

    // Immediate ALU B operand for everything except register-register ops.
    function automatic logic uses_imm(input logic [OPW-1:0] op);
        uses_imm = (op != OP_RTYPE) && (op != OP_BEQ);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            op_q      <= '0;
            funct_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            funct_q   <= funct_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        funct_d    = funct_q;
        illegal_d  = illegal_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        branch     = 1'b0;
        mem_read   = 1'b0;
        mem_to_reg = 1'b0;
        alu_op     = ALU_ADD;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        reg_write  = 1'b0;

        case (state_q)
            FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
                state_d  = DECODE;
            end
            DECODE: begin
                op_d    = bus.instr_op;
                funct_d = bus.funct;
                if (is_supported(bus.instr_op)) begin
                    state_d = EXEC;
                end else begin
                    state_d   = FETCH;
                    illegal_d = 1'b1;
                end
            end
            EXEC: begin
                alu_op  = exec_alu_op(op_q);
                alu_src = uses_imm(op_q);
                reg_dst = (op_q == OP_RTYPE);
                branch  = (op_q == OP_BEQ);
                if (op_q == OP_BEQ) begin
                    state_d = FETCH;
                end else if ((op_q == OP_LW) || (op_q == OP_SW)) begin
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                alu_op    = ALU_ADD;
                alu_src   = 1'b1;
                mem_read  = (op_q == OP_LW);
                mem_write = (op_q == OP_SW);
                if (bus.mem_ready) begin
                    state_d = (op_q == OP_LW) ? WB : FETCH;
                end
            end
            WB: begin
                alu_op     = exec_alu_op(op_q);
                alu_src    = uses_imm(op_q);
                reg_dst    = (op_q == OP_RTYPE);
                mem_to_reg = (op_q == OP_LW);
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // Combinational kill so a reset asserted mid-instruction issues no write.
        if (rst) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            reg_dst    = 1'b0;
            branch     = 1'b0;
            mem_read   = 1'b0;
            mem_to_reg = 1'b0;
            alu_op     = ALU_ADD;
            mem_write  = 1'b0;
            alu_src    = 1'b0;
            reg_write  = 1'b0;
        end
    end

    assign bus.pc_write   = pc_write;
    assign bus.ir_write   = ir_write;
    assign bus.reg_dst    = reg_dst;
    assign bus.branch     = branch;
    assign bus.mem_read   = mem_read;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.alu_op     = alu_op;
    assign bus.mem_write  = mem_write;
    assign bus.alu_src    = alu_src;
    assign bus.reg_write  = reg_write;
    assign bus.illegal_op = illegal_q;
    assign bus.state_dbg  = state_q;

    // The datapath's alu_control decodes funct itself; the latched copy is kept for debug taps.
    logic unused_funct;
    assign unused_funct = ^funct_q;

`ifdef CS161_CTRL_PERF_EN
    logic [31:0] retired_q, retired_d;
    logic        retire;

    always_comb begin
        retire = 1'b0;
        case (state_q)
            WB:      retire = 1'b1;
            MEM:     retire = (op_q == OP_SW) && bus.mem_ready;
            EXEC:    retire = (op_q == OP_BEQ);
            default: retire = 1'b0;
        endcase
        retired_d = retired_q + {31'd0, retire};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired_count = retired_q;
`endif

endmodule

// File: tb/tb_cs161_control_fsm.sv
// Directed scoreboard bench for cs161_control_fsm; honours CS161_CTRL_PERF_EN.
module tb_cs161_control_fsm;

    logic clk;
    logic rst;

    cs161_control_fsm_if #(.OPW(6), .ALUOPW(4)) bus ();

`ifdef CS161_CTRL_PERF_EN
    logic [31:0] retired_count;
    cs161_control_fsm #(.OPW(6), .ALUOPW(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .retired_count (retired_count)
    );
`else
    cs161_control_fsm #(.OPW(6), .ALUOPW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [16:0] v;
        logic [31:0] ret;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_ret  = 0;
    logic        mx_en    = 1'b0;

    // Field order: state, pc_write, ir_write, reg_dst, branch, mem_read,
    // mem_to_reg, alu_op, mem_write, alu_src, reg_write, illegal_op.
    function automatic logic [16:0] ctl(input logic [2:0] st, input logic pcw, input logic irw,
                                        input logic rd, input logic br, input logic mr,
                                        input logic m2r, input logic [3:0] aop, input logic mw,
                                        input logic as, input logic rw, input logic ill);
        return {st, pcw, irw, rd, br, mr, m2r, aop, mw, as, rw, ill};
    endfunction

    function automatic logic [16:0] observed();
        return {bus.state_dbg, bus.pc_write, bus.ir_write, bus.reg_dst, bus.branch,
                bus.mem_read, bus.mem_to_reg, bus.alu_op, bus.mem_write, bus.alu_src,
                bus.reg_write, bus.illegal_op};
    endfunction

    // Drive one cycle's inputs, check the Moore outputs for that cycle, then advance.
    task automatic step(input string tag, input logic r, input logic [5:0] op,
                        input logic [5:0] fn, input logic rdy, input logic [16:0] e);
        exp_t x;
        exp_t got;
        logic [16:0] obs;
        rst           = r;
        bus.instr_op  = op;
        bus.funct     = fn;
        bus.mem_ready = rdy;
        x.tag = tag;
        x.v   = e;
        x.ret = exp_ret;
        sb.push_back(x);
        #1;
        got = sb.pop_front();
        obs = observed();
        checks++;
        assert (obs === got.v) else begin
            failures++;
            $error("FAIL %s observed=%05h expected=%05h", got.tag, obs, got.v);
        end
`ifdef CS161_CTRL_PERF_EN
        checks++;
        assert (retired_count === got.ret) else begin
            failures++;
            $error("FAIL %s_retired observed=%0d expected=%0d", got.tag, retired_count, got.ret);
        end
`endif
        @(posedge clk);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (mx_en) begin
            checks++;
            assert (((32'(bus.mem_read) + 32'(bus.mem_write) + 32'(bus.reg_write)) <= 1)
                    && !(bus.pc_write && bus.branch)) else begin
                failures++;
                $error("FAIL mutex observed=mr%b mw%b rw%b pcw%b br%b expected=exclusive",
                       bus.mem_read, bus.mem_write, bus.reg_write, bus.pc_write, bus.branch);
            end
        end
    end

    initial begin
        rst           = 1'b1;
        bus.instr_op  = 6'h00;
        bus.funct     = 6'h00;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        mx_en = 1'b1;

        step("reset",     1, 6'h00, 6'h00, 0, ctl(0,0,0,0,0,0,0,4'b0000,0,0,0,0));

        // R-type add, live opcode changed during EXEC/WB to prove latching
        step("r_fetch",   0, 6'h00, 6'h20, 0, ctl(0,1,1,0,0,0,0,4'b0000,0,0,0,0));
        step("r_decode",  0, 6'h00, 6'h20, 0, ctl(1,0,0,0,0,0,0,4'b0000,0,0,0,0));
        step("r_exec",    0, 6'h3F, 6'h00, 1, ctl(2,0,0,1,0,0,0,4'b0010,0,0,0,0));
        step("r_wb",      0, 6'h23, 6'h00, 1, ctl(4,0,0,1,0,0,0,4'b0010,0,0,1,0));
        exp_ret++;

        // lw, mem_ready high outside MEM must be ignored, two stall cycles
        step("lw_fetch",  0, 6'h23, 6'h00, 1, ctl(0,1,1,0,0,0,0,4'b0000,0,0,0,0));
        step("lw_decode", 0, 6'h23, 6'h00, 1, ctl(1,0,0,0,0,0,0,4'b0000,0,0,0,0));
        step("lw_exec",   0, 6'h2B, 6'h00, 1, ctl(2,0,0,0,0,0,0,4'b0000,0,1,0,0));
        step("lw_mem0",   0, 6'h00, 6'h00, 0, ctl(3,0,0,0,0,1,0,4'b0000,0,1,0,0));
        step("lw_mem1",   0, 6'h00, 6'h00, 0, ctl(3,0,0,0,0,1,0,4'b0000,0,1,0,0));
        step("lw_mem2",   0, 6'h00, 6'h00, 1, ctl(3,0,0,0,0,1,0,4'b0000,0,1,0,0));
        step("lw_wb",     0, 6'h00, 6'h00, 0, ctl(4,0,0,0,0,0,1,4'b0000,0,1,1,0));
        exp_ret++;

        // sw, ready immediately
        step("sw_fetch",  0, 6'h2B, 6'h00, 1, ctl(0,1,1,0,0,0,0,4'b0000,0,0,0,0));
        step("sw_decode", 0, 6'h2B, 6'h00, 1, ctl(1,0,0,0,0,0,0,4'b0000,0,0,0,0));
        step("sw_exec",   0, 6'h2B, 6'h00, 1, ctl(2,0,0,0,0,0,0,4'b0000,0,1,0,0));
        step("sw_mem",    0, 6'h2B, 6'h00, 1, ctl(3,0,0,0,0,0,0,4'b0000,1,1,0,0));
        exp_ret++;

        // beq resolves in EXEC
        step("beq_fetch", 0, 6'h04, 6'h00, 0, ctl(0,1,1,0,0,0,0,4'b0000,0,0,0,0));
        step("beq_decode",0, 6'h04, 6'h00, 0, ctl(1,0,0,0,0,0,0,4'b0000,0,0,0,0));
        step("beq_exec",  0, 6'h04, 6'h00, 0, ctl(2,0,0,0,1,0,0,4'b0001,0,0,0,0));
        exp_ret++;

        // illegal opcode then addi; sticky flag
        step("ill_fetch", 0, 6'h3F, 6'h00, 0, ctl(0,1,1,0,0,0,0,4'b0000,0,0,0,0));
        step("ill_decode",0, 6'h3F, 6'h00, 0, ctl(1,0,0,0,0,0,0,4'b0000,0,0,0,0));
        step("ad_fetch",  0, 6'h08, 6'h00, 0, ctl(0,1,1,0,0,0,0,4'b0000,0,0,0,1));
        step("ad_decode", 0, 6'h08, 6'h00, 0, ctl(1,0,0,0,0,0,0,4'b0000,0,0,0,1));
        step("ad_exec",   0, 6'h08, 6'h00, 0, ctl(2,0,0,0,0,0,0,4'b0000,0,1,0,1));
        step("ad_wb",     0, 6'h08, 6'h00, 0, ctl(4,0,0,0,0,0,0,4'b0000,0,1,1,1));
        exp_ret++;

        // lw aborted by reset during a MEM stall
        step("ab_fetch",  0, 6'h23, 6'h00, 0, ctl(0,1,1,0,0,0,0,4'b0000,0,0,0,1));
        step("ab_decode", 0, 6'h23, 6'h00, 0, ctl(1,0,0,0,0,0,0,4'b0000,0,0,0,1));
        step("ab_exec",   0, 6'h23, 6'h00, 0, ctl(2,0,0,0,0,0,0,4'b0000,0,1,0,1));
        step("ab_mem0",   0, 6'h23, 6'h00, 0, ctl(3,0,0,0,0,1,0,4'b0000,0,1,0,1));
        step("ab_mem_rst",1, 6'h23, 6'h00, 1, ctl(3,0,0,0,0,0,0,4'b0000,0,0,0,1));
        exp_ret = 0;
        step("ab_rst_hold",1, 6'h23, 6'h00, 1, ctl(0,0,0,0,0,0,0,4'b0000,0,0,0,0));
        step("ab_refetch",0, 6'h00, 6'h20, 1, ctl(0,1,1,0,0,0,0,4'b0000,0,0,0,0));
        step("ab_decode2",0, 6'h00, 6'h20, 1, ctl(1,0,0,0,0,0,0,4'b0000,0,0,0,0));
        step("ab_exec2",  0, 6'h00, 6'h20, 1, ctl(2,0,0,1,0,0,0,4'b0010,0,0,0,0));

        mx_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
